conv_host_mem: RTL
==================

# conv_host_mem

Host-side responder for the convolution engine's memory interface. Accepts a 64x64 image over a valid/ready stream into an image buffer, raises `ready` to launch the engine, and serves its image reads (`iaddr`/`idata`) and layer-memory traffic (`cwr`/`crd`/`csel`). Once the engine drops `busy`, it streams the 2048-word layer-2 (flatten) result back out. It is the other end of the engine's image-ROM and layer-RAM ports.

## Interface
Parameters:
- `DW`, 20: data width, signed fixed point (4.16)
- `IMG_DEPTH`, 4096: image buffer words (64x64)
- `L2_DEPTH`, 2048: layer-2 words streamed out

Ports:
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `in_valid` in 1, `in_ready` out 1, `in_data` in DW: image load stream, raster order
- `ready` out 1: engine start request
- `busy` in 1: engine busy
- `iaddr` in 12, `idata` out DW: image read port
- `cwr` in 1, `caddr_wr` in 12, `cdata_wr` in DW: layer write port
- `crd` in 1, `caddr_rd` in 12, `cdata_rd` out DW: layer read port
- `csel` in 3: layer bank select
- `out_valid` out 1, `out_ready` in 1, `out_data` out DW: result stream
- `done` out 1: one-cycle frame-complete pulse
- `err` out 1: sticky write-error flag (see Configuration)

## Operation
- Banks by `csel`: 001 L0/k0 (4096), 010 L0/k1 (4096), 011 L1/k0 (1024), 100 L1/k1 (1024), 101 L2 (2048). 000, 110, 111 are no bank.
- FSM states: LOAD, KICK, RUN, DUMP, DONE. Reset enters LOAD.
- LOAD: `in_ready`=1. Each `in_valid&&in_ready` beat writes img[ld_cnt] and increments ld_cnt. Beat 4095 moves to KICK and clears ld_cnt.
- KICK: `ready`=1. When `busy`=1 is sampled, go to RUN; `ready` drops in the same transition.
- RUN: on `cwr`, write bank[csel][caddr_wr] <= cdata_wr at the clock edge. A write to a no-bank csel or an address >= bank depth is dropped. When `busy`=0 is sampled, go to DUMP.
- Reads are combinational in every state:
  - `idata` = img[iaddr].
  - `cdata_rd` = bank[csel][caddr_rd] when `crd`=1 and the address is in range; otherwise 0.
- DUMP: `out_valid`=1, `out_data`=L2[dp_cnt]. dp_cnt advances on `out_valid&&out_ready`. The beat with dp_cnt=2047 moves to DONE.
- DONE: `done`=1 for exactly one cycle, then LOAD. Counters are cleared.
- Memory contents are never cleared by reset or by a new frame. L2 is fully overwritten each run.

## Timing
- Reset values: `in_ready`=1 (state LOAD), `ready`=0, `idata`/`cdata_rd` purely combinational, `out_valid`=0, `out_data`=L2[0], `done`=0, `err`=0. All counters are 0.
- Read latency: 0 cycles. The engine samples `idata`/`cdata_rd` in the same cycle it drives the address.
- Write latency: 1 edge. A read of the same bank and address in the write cycle returns the old word; the next cycle returns the new word.
- `ready` rises the cycle after the final load beat. It is held until `busy`=1, with no timeout.
- RUN must see `busy`=1 for at least one cycle before its falling edge counts. A `busy` low in the KICK→RUN transition cycle is ignored.
- `out_data` is stable while `out_valid && !out_ready`.
- Reset mid-operation returns the block to LOAD immediately: `ready`, `out_valid`, and `done` go to 0, and a partial load is discarded.

## Configuration
- `CONV_HOST_WR_CHECK_EN` defined:
  - `err` sets on any `cwr` in RUN with a no-bank csel or an out-of-range `caddr_wr`.
  - `err` also sets on any `cwr` outside RUN.
  - Once set, `err` clears only on `reset`.
- `CONV_HOST_WR_CHECK_EN` not defined: `err` is tied to 0 and the check logic is absent. Write dropping is unchanged.

## Test plan
- Load 4096 beats with img[n]=n and `in_valid` gapped every 3rd cycle -> `ready` rises the cycle after beat 4095. Then iaddr=0x0FFF gives idata=0x00FFF.
- In KICK, hold `busy`=0 for 10 cycles, then assert it -> `ready` stays 1 for 10 cycles and is 0 the cycle after `busy` is sampled high.
- In RUN: csel=011, cwr, caddr_wr=0x3FF, cdata_wr=0x12345. Next cycle crd, caddr_rd=0x3FF -> cdata_rd=0x12345. Same write at caddr_wr=0x400 is dropped: that read returns 0, and with CONV_HOST_WR_CHECK_EN `err`=1.
- Write L2[k]=k for k=0..2047, drop `busy`, toggle `out_ready` 1/0 -> 2048 beats out_data=0..2047 in order, then `done` high one cycle, then `in_ready`=1.
- Same-cycle write and read of L0/k1 addr 5 (old 0xAAAAA, new 0x55555) -> cdata_rd=0xAAAAA in that cycle and 0x55555 the next.
- Assert `reset` mid-DUMP at beat 100 -> `out_valid`=0 and state LOAD. A fresh frame then dumps from L2[0].

Source files
------------

// File: rtl/conv_host_mem_if.sv
// conv_host_mem_if: image stream, engine handshake, memory ports and result stream of conv_host_mem
interface conv_host_mem_if #(parameter int DW = 20);
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          ready, busy;
  logic [11:0]   iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [11:0]   caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [11:0]   caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          done, err;
  modport master (
    output in_valid, in_data, busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, out_ready,
    input  in_ready, ready, idata, cdata_rd, out_valid, out_data, done, err
  );
  modport slave (
    input  in_valid, in_data, busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, out_ready,
    output in_ready, ready, idata, cdata_rd, out_valid, out_data, done, err
  );
endinterface

// File: rtl/conv_host_mem.sv
// conv_host_mem: host-side image/layer memory responder for the conv engine; CONV_HOST_WR_CHECK_EN enables the sticky write-error flag
module conv_host_mem #(
  parameter int DW        = 20,
  parameter int IMG_DEPTH = 4096,
  parameter int L2_DEPTH  = 2048
) (
  input logic            clk,
  input logic            reset,
  conv_host_mem_if.slave bus
);
  localparam int LW  = $clog2(IMG_DEPTH);
  localparam int DPW = $clog2(L2_DEPTH);
  typedef enum logic [2:0] {LOAD, KICK, RUN, DUMP, DONE} state_t;
  state_t        state, state_n;
  logic [LW-1:0]  ld_cnt;
  logic [DPW-1:0] dp_cnt;
  logic           run_seen;
  logic [DW-1:0]  img  [IMG_DEPTH];
  logic [DW-1:0]  l0k0 [4096];
  logic [DW-1:0]  l0k1 [4096];
  logic [DW-1:0]  l1k0 [1024];
  logic [DW-1:0]  l1k1 [1024];
  logic [DW-1:0]  l2   [L2_DEPTH];
  logic ld_fire, ld_last, dp_fire, dp_last, wr_ok, we, l1_rd_in, l2_rd_in;
  assign ld_fire  = state == LOAD && bus.in_valid;
  assign ld_last  = ld_cnt == LW'(IMG_DEPTH - 1);
  assign dp_fire  = state == DUMP && bus.out_ready;
  assign dp_last  = dp_cnt == DPW'(L2_DEPTH - 1);
  assign wr_ok    = bus.csel == 3'd1 || bus.csel == 3'd2 ||
                    ((bus.csel == 3'd3 || bus.csel == 3'd4) && bus.caddr_wr < 12'd1024) ||
                    (bus.csel == 3'd5 && bus.caddr_wr < 12'(L2_DEPTH));
  assign we       = state == RUN && bus.cwr && wr_ok;
  assign l1_rd_in = bus.caddr_rd < 12'd1024;
  assign l2_rd_in = bus.caddr_rd < 12'(L2_DEPTH);
  assign bus.in_ready  = state == LOAD;
  assign bus.ready     = state == KICK;
  assign bus.out_valid = state == DUMP;
  assign bus.done      = state == DONE;
  assign bus.out_data  = l2[dp_cnt];
  assign bus.idata     = img[bus.iaddr];
  assign bus.cdata_rd  = !bus.crd ? '0 :
                         bus.csel == 3'd1 ? l0k0[bus.caddr_rd] :
                         bus.csel == 3'd2 ? l0k1[bus.caddr_rd] :
                         bus.csel == 3'd3 && l1_rd_in ? l1k0[bus.caddr_rd[9:0]] :
                         bus.csel == 3'd4 && l1_rd_in ? l1k1[bus.caddr_rd[9:0]] :
                         bus.csel == 3'd5 && l2_rd_in ? l2[bus.caddr_rd[DPW-1:0]] : '0;
  // frame sequencing: load image, request start, serve engine, stream L2, pulse done
  always_comb begin
    state_n = state;
    case (state)
      LOAD:    state_n = ld_fire && ld_last ? KICK : LOAD;
      KICK:    state_n = bus.busy ? RUN : KICK;
      RUN:     state_n = !bus.busy && run_seen ? DUMP : RUN;
      DUMP:    state_n = dp_fire && dp_last ? DONE : DUMP;
      default: state_n = LOAD;
    endcase
  end
  // state, counters and the busy-seen qualifier that keeps RUN from ending before the engine starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LOAD;
      ld_cnt   <= '0;
      dp_cnt   <= '0;
      run_seen <= 1'b0;
    end else begin
      state    <= state_n;
      run_seen <= state == RUN && (run_seen || bus.busy);
      if (state == DONE) begin
        ld_cnt <= '0;
        dp_cnt <= '0;
      end else begin
        if (ld_fire) ld_cnt <= ld_last ? '0 : ld_cnt + 1'b1;
        if (dp_fire) dp_cnt <= dp_last ? '0 : dp_cnt + 1'b1;
      end
    end
  end
  // memory writes; contents survive reset and new frames
  always_ff @(posedge clk) begin
    if (ld_fire) img[ld_cnt] <= bus.in_data;
    if (we && bus.csel == 3'd1) l0k0[bus.caddr_wr] <= bus.cdata_wr;
    if (we && bus.csel == 3'd2) l0k1[bus.caddr_wr] <= bus.cdata_wr;
    if (we && bus.csel == 3'd3) l1k0[bus.caddr_wr[9:0]] <= bus.cdata_wr;
    if (we && bus.csel == 3'd4) l1k1[bus.caddr_wr[9:0]] <= bus.cdata_wr;
    if (we && bus.csel == 3'd5) l2[bus.caddr_wr[DPW-1:0]] <= bus.cdata_wr;
  end
`ifdef CONV_HOST_WR_CHECK_EN
  logic err_q;
  // sticky flag for any write that is dropped or arrives outside RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else if (bus.cwr && (state != RUN || !wr_ok)) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule
